// File: rtl/move_enable_arbiter.sv
// move_enable_arbiter: accepts one direction request at a time and checks it
// against a snapshot of that direction's per-cell enable vector. An approved
// move is handed to the grid and the arbiter then waits, with a timeout, for
// the grid to report completion.
// Optional feature: define MOVE_LR_MASK_EN so that left/right requests are
// also checked against left_en/right_en. When it is undefined those enables
// are ignored and left/right always pass.

// Registered all-cells-enabled flag for a single direction.
module move_dir_flag #(
   parameter int W = 24
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] en,
   output logic         ok
);
   // One-cycle registered AND-reduction of the enable vector.
   always_ff @(posedge clk) begin
      if (rst) ok <= 1'b0;
      else     ok <= &en;
   end
endmodule

module move_enable_arbiter #(
   parameter int ROWS    = 4,
   parameter int COLS    = 6,
   parameter int TIMEOUT = 1024
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [ROWS*COLS-1:0] up_en,
   input  logic [ROWS*COLS-1:0] down_en,
   input  logic [ROWS*COLS-1:0] left_en,
   input  logic [ROWS*COLS-1:0] right_en,
   input  logic                 dir_req_valid,
   input  logic [1:0]           dir_req,
   output logic                 dir_req_ready,
   output logic                 move_valid,
   output logic [1:0]           move_dir,
   input  logic                 move_ready,
   input  logic                 move_done,
   output logic                 move_reject,
   output logic                 move_timeout,
   output logic [3:0]           dir_ok,
   input  logic                 clear_stats,
   output logic [7:0]           reject_cnt
);
   localparam int NCELL = ROWS * COLS;
   localparam logic [15:0] TOUT_LAST = 16'(TIMEOUT - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] CHECK = 2'd1;
   localparam logic [1:0] ISSUE = 2'd2;
   localparam logic [1:0] WAIT  = 2'd3;

   logic [1:0]             stateQ;
   logic [1:0]             dirQ;
   logic [NCELL-1:0]       snapQ;
   logic [15:0]            timeoutCnt;
   logic [3:0][NCELL-1:0]  enVec;
   logic                   snapAllOnes;
   logic                   rejectEvt;

   // Effective enable vector per direction, indexed by the direction code.
   assign enVec[0] = up_en;
   assign enVec[1] = down_en;
`ifdef MOVE_LR_MASK_EN
   assign enVec[2] = left_en;
   assign enVec[3] = right_en;
`else
   // Left/right are unmasked: OR-ing with all-ones forces them enabled while
   // still consuming the ports.
   assign enVec[2] = left_en  | {NCELL{1'b1}};
   assign enVec[3] = right_en | {NCELL{1'b1}};
`endif

   // Per-direction status flags, one flag instance per direction.
   for (genvar d = 0; d < 4; d++) begin : gFlag
      move_dir_flag #(.W(NCELL)) uFlag (
         .clk (clk),
         .rst (rst),
         .en  (enVec[d]),
         .ok  (dir_ok[d])
      );
   end

   assign snapAllOnes = &snapQ;
   assign rejectEvt   = (stateQ == CHECK) && !snapAllOnes;

   // Request FSM; every output is a register updated alongside the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         stateQ        <= IDLE;
         dirQ          <= 2'd0;
         snapQ         <= '0;
         timeoutCnt    <= 16'd0;
         dir_req_ready <= 1'b1;
         move_valid    <= 1'b0;
         move_dir      <= 2'd0;
         move_reject   <= 1'b0;
         move_timeout  <= 1'b0;
      end else begin
         move_reject  <= 1'b0;
         move_timeout <= 1'b0;
         case (stateQ)
            IDLE: begin
               // Only the snapshot taken here decides the outcome.
               if (dir_req_valid && dir_req_ready) begin
                  dirQ          <= dir_req;
                  snapQ         <= enVec[dir_req];
                  dir_req_ready <= 1'b0;
                  stateQ        <= CHECK;
               end
            end
            CHECK: begin
               if (snapAllOnes) begin
                  move_valid <= 1'b1;
                  move_dir   <= dirQ;
                  stateQ     <= ISSUE;
               end else begin
                  move_reject   <= 1'b1;
                  dir_req_ready <= 1'b1;
                  stateQ        <= IDLE;
               end
            end
            ISSUE: begin
               // move_valid/move_dir hold until the grid takes the move.
               if (move_ready) begin
                  move_valid <= 1'b0;
                  timeoutCnt <= 16'd0;
                  stateQ     <= WAIT;
               end
            end
            default: begin
               // WAIT: completion wins over a timeout on the same cycle.
               if (move_done) begin
                  timeoutCnt    <= 16'd0;
                  dir_req_ready <= 1'b1;
                  stateQ        <= IDLE;
               end else if (timeoutCnt == TOUT_LAST) begin
                  move_timeout  <= 1'b1;
                  timeoutCnt    <= 16'd0;
                  dir_req_ready <= 1'b1;
                  stateQ        <= IDLE;
               end else begin
                  timeoutCnt <= timeoutCnt + 16'd1;
               end
            end
         endcase
      end
   end

   // Saturating reject counter; a clear beats a same-cycle increment.
   always_ff @(posedge clk) begin
      if (rst || clear_stats)                 reject_cnt <= 8'd0;
      else if (rejectEvt && reject_cnt != 8'hFF) reject_cnt <= reject_cnt + 8'd1;
   end
endmodule

// File: tb/tb_move_enable_arbiter.sv
// Directed bench for move_enable_arbiter with ROWS=4, COLS=6, TIMEOUT=16.
// Cycle numbers in comments count from the request's accept cycle (cycle 0).
module tb_move_enable_arbiter;
   logic        clk = 1'b0;
   logic        rst;
   logic [23:0] up_en, down_en, left_en, right_en;
   logic        dir_req_valid;
   logic [1:0]  dir_req;
   logic        dir_req_ready;
   logic        move_valid;
   logic [1:0]  move_dir;
   logic        move_ready, move_done;
   logic        move_reject, move_timeout;
   logic [3:0]  dir_ok;
   logic        clear_stats;
   logic [7:0]  reject_cnt;

   int errors = 0;
   int checks = 0;

   move_enable_arbiter #(.ROWS(4), .COLS(6), .TIMEOUT(16)) dut (
      .clk(clk), .rst(rst),
      .up_en(up_en), .down_en(down_en), .left_en(left_en), .right_en(right_en),
      .dir_req_valid(dir_req_valid), .dir_req(dir_req), .dir_req_ready(dir_req_ready),
      .move_valid(move_valid), .move_dir(move_dir), .move_ready(move_ready),
      .move_done(move_done), .move_reject(move_reject), .move_timeout(move_timeout),
      .dir_ok(dir_ok), .clear_stats(clear_stats), .reject_cnt(reject_cnt)
   );

   always #5 clk = ~clk;

   // Advance one cycle; inputs are changed and outputs sampled 1 time unit
   // after the rising edge.
   task automatic cyc(input int n = 1);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // Offer a request for one cycle (cycle 0); returns at cycle 1.
   task automatic request(input logic [1:0] d);
      dir_req = d; dir_req_valid = 1'b1;
      cyc();
      dir_req_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cyc(3);
      checks++; if (move_valid !== 1'b0) begin errors++; $display("FAIL rst_move_valid got %b exp 0", move_valid); end
      checks++; if (move_dir !== 2'd0) begin errors++; $display("FAIL rst_move_dir got %0d exp 0", move_dir); end
      checks++; if (move_reject !== 1'b0 || move_timeout !== 1'b0) begin errors++; $display("FAIL rst_pulses got %b%b exp 00", move_reject, move_timeout); end
      checks++; if (dir_ok !== 4'b0000) begin errors++; $display("FAIL rst_dir_ok got %b exp 0000", dir_ok); end
      checks++; if (reject_cnt !== 8'd0) begin errors++; $display("FAIL rst_reject_cnt got %0d exp 0", reject_cnt); end
      rst = 1'b0;
      cyc();
      checks++; if (dir_req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", dir_req_ready); end
`ifdef MOVE_LR_MASK_EN
      checks++; if (dir_ok !== 4'b1001) begin errors++; $display("FAIL dir_ok got %b exp 1001", dir_ok); end
`else
      checks++; if (dir_ok !== 4'b1101) begin errors++; $display("FAIL dir_ok got %b exp 1101", dir_ok); end
`endif
   endtask

   task automatic test_issue();
      move_ready = 1'b1;
      request(2'd0);                                  // now cycle 1
      checks++; if (dir_req_ready !== 1'b0 || move_valid !== 1'b0) begin errors++; $display("FAIL issue_c1 got rdy=%b vld=%b exp 0 0", dir_req_ready, move_valid); end
      cyc();                                          // cycle 2
      checks++; if (move_valid !== 1'b1 || move_dir !== 2'd0) begin errors++; $display("FAIL issue_c2 got vld=%b dir=%0d exp 1 0", move_valid, move_dir); end
      cyc();                                          // cycle 3 (WAIT)
      checks++; if (move_valid !== 1'b0) begin errors++; $display("FAIL issue_c3 got vld=%b exp 0", move_valid); end
      cyc(2); move_done = 1'b1;                       // cycle 5
      checks++; if (dir_req_ready !== 1'b0) begin errors++; $display("FAIL issue_c5 got rdy=%b exp 0", dir_req_ready); end
      cyc(); move_done = 1'b0;                        // cycle 6
      checks++; if (dir_req_ready !== 1'b1) begin errors++; $display("FAIL issue_c6 got rdy=%b exp 1", dir_req_ready); end
   endtask

   task automatic test_reject();
      request(2'd1);                                  // cycle 1
      cyc();                                          // cycle 2
      checks++; if (move_reject !== 1'b1 || move_valid !== 1'b0) begin errors++; $display("FAIL reject_c2 got rej=%b vld=%b exp 1 0", move_reject, move_valid); end
      cyc();                                          // cycle 3
      checks++; if (move_reject !== 1'b0) begin errors++; $display("FAIL reject_pulse got %b exp 0", move_reject); end
      checks++; if (reject_cnt !== 8'd1) begin errors++; $display("FAIL reject_cnt got %0d exp 1", reject_cnt); end
      checks++; if (dir_req_ready !== 1'b1) begin errors++; $display("FAIL reject_ready got %b exp 1", dir_req_ready); end
   endtask

   task automatic test_snapshot();
      // Up allowed at accept, cleared afterwards: still issued; grid stalls.
      move_ready = 1'b0;
      request(2'd0);
      up_en = 24'hFFFFFE;
      cyc(3);                                         // cycle 4, stalled in ISSUE
      checks++; if (move_valid !== 1'b1 || move_dir !== 2'd0) begin errors++; $display("FAIL snap_hold got vld=%b dir=%0d exp 1 0", move_valid, move_dir); end
      move_ready = 1'b1;
      cyc();                                          // WAIT
      checks++; if (move_valid !== 1'b0) begin errors++; $display("FAIL snap_drop got vld=%b exp 0", move_valid); end
      move_done = 1'b1; cyc(); move_done = 1'b0;
      up_en = 24'hFFFFFF;
      // Down blocked at accept, enabled afterwards: still rejected.
      request(2'd1);
      down_en = 24'hFFFFFF;
      cyc();
      checks++; if (move_reject !== 1'b1 || move_valid !== 1'b0) begin errors++; $display("FAIL snap_reject got rej=%b vld=%b exp 1 0", move_reject, move_valid); end
      down_en = 24'hFFFFFE;
      cyc();
   endtask

   task automatic test_timeout();
      move_ready = 1'b1;
      move_done = 1'b1;                               // ignored outside WAIT
      request(2'd0);                                  // cycle 1
      cyc(2); move_done = 1'b0;                       // cycle 3: WAIT entry
      cyc(15);                                        // cycle 18
      checks++; if (move_timeout !== 1'b0 || dir_req_ready !== 1'b0) begin errors++; $display("FAIL tout_early got to=%b rdy=%b exp 0 0", move_timeout, dir_req_ready); end
      cyc();                                          // cycle 19
      checks++; if (move_timeout !== 1'b1 || dir_req_ready !== 1'b1) begin errors++; $display("FAIL tout_pulse got to=%b rdy=%b exp 1 1", move_timeout, dir_req_ready); end
      cyc();
      checks++; if (move_timeout !== 1'b0) begin errors++; $display("FAIL tout_width got %b exp 0", move_timeout); end
      // Completion on the last counted cycle suppresses the timeout.
      request(2'd0);
      cyc(17); move_done = 1'b1;                      // cycle 18
      cyc(); move_done = 1'b0;                        // cycle 19
      checks++; if (move_timeout !== 1'b0 || dir_req_ready !== 1'b1) begin errors++; $display("FAIL tout_done_wins got to=%b rdy=%b exp 0 1", move_timeout, dir_req_ready); end
   endtask

   task automatic test_lr_mask();
      logic expVld;
      logic expRej;
`ifdef MOVE_LR_MASK_EN
      expVld = 1'b0; expRej = 1'b1;
`else
      expVld = 1'b1; expRej = 1'b0;
`endif
      move_ready = 1'b1;
      request(2'd2);
      cyc();                                          // cycle 2
      checks++; if (move_valid !== expVld || move_reject !== expRej) begin errors++; $display("FAIL lr_left got vld=%b rej=%b exp %b %b", move_valid, move_reject, expVld, expRej); end
      checks++; if (dir_ok[2] !== expVld) begin errors++; $display("FAIL lr_dir_ok2 got %b exp %b", dir_ok[2], expVld); end
      if (expVld) begin
         cyc(); move_done = 1'b1; cyc(); move_done = 1'b0;
      end
      cyc();
   endtask

   task automatic test_reset_wait();
      int toSeen;
      toSeen = 0;
      move_ready = 1'b1;
      request(2'd0);
      cyc(4);                                         // cycle 5, in WAIT
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      checks++; if (move_valid !== 1'b0 || move_reject !== 1'b0) begin errors++; $display("FAIL rstwait_out got vld=%b rej=%b exp 0 0", move_valid, move_reject); end
      cyc();
      checks++; if (dir_req_ready !== 1'b1) begin errors++; $display("FAIL rstwait_ready got %b exp 1", dir_req_ready); end
      for (int i = 0; i < 20; i++) begin
         if (move_timeout === 1'b1) toSeen++;
         cyc();
      end
      checks++; if (toSeen !== 0) begin errors++; $display("FAIL rstwait_timeout got %0d pulses exp 0", toSeen); end
   endtask

   task automatic test_saturate();
      int pulses;
      int budget;
      pulses = 0; budget = 2000;
      dir_req = 2'd1; dir_req_valid = 1'b1;
      while (pulses < 300 && budget > 0) begin
         cyc(); budget--;
         if (move_reject === 1'b1) pulses++;
      end
      dir_req_valid = 1'b0;
      checks++; if (pulses !== 300) begin errors++; $display("FAIL sat_pulses got %0d exp 300", pulses); end
      cyc(3);
      checks++; if (reject_cnt !== 8'd255) begin errors++; $display("FAIL sat_cnt got %0d exp 255", reject_cnt); end
      clear_stats = 1'b1; cyc(); clear_stats = 1'b0;
      checks++; if (reject_cnt !== 8'd0) begin errors++; $display("FAIL clear_cnt got %0d exp 0", reject_cnt); end
      request(2'd1); cyc(2);
      checks++; if (reject_cnt !== 8'd1) begin errors++; $display("FAIL cnt_after_clear got %0d exp 1", reject_cnt); end
      // Clear during the CHECK cycle beats the increment.
      request(2'd1);                                  // cycle 1 (CHECK)
      clear_stats = 1'b1;
      cyc(); clear_stats = 1'b0;                      // cycle 2
      checks++; if (reject_cnt !== 8'd0 || move_reject !== 1'b1) begin errors++; $display("FAIL clear_wins got cnt=%0d rej=%b exp 0 1", reject_cnt, move_reject); end
      cyc(2);
   endtask

   initial begin
      rst = 1'b1;
      up_en = 24'hFFFFFF; down_en = 24'hFFFFFE; left_en = 24'h000000; right_en = 24'hFFFFFF;
      dir_req_valid = 1'b0; dir_req = 2'd0;
      move_ready = 1'b0; move_done = 1'b0; clear_stats = 1'b0;
      #1;
      test_reset();
      test_issue();
      test_reject();
      test_snapshot();
      test_timeout();
      test_lr_mask();
      test_reset_wait();
      test_saturate();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
